// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter: shifts a captured pattern out LSB-first on w,
// holding each bit for TICK_DIV clocks, with start/busy/done handshake.
module serial_pattern_tx #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned TICK_DIV = 4,
    parameter logic        IDLE_LVL = 1'b0,
    localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LW-1:0]      len,
    output logic               w,
    output logic               bit_vld,
    output logic               busy,
    output logic               done
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StLoad  = 4'b0010,
        StShift = 4'b0100,
        StDone  = 4'b1000
    } state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic [LW-1:0]      bc_q, bc_d;
    logic [TW-1:0]      tc_q, tc_d;
    logic               w_q, w_d;
    logic               bit_vld_q, bit_vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bc_d    = bc_q;
        tc_d    = tc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    sr_d    = pattern;
                    bc_d    = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
                    tc_d    = '0;
                end
            end
            StLoad: begin
                tc_d    = '0;
                state_d = (bc_q != '0) ? StShift : StDone;
            end
            StShift: begin
                if (tc_q == TW'(TICK_DIV - 1)) begin
                    tc_d = '0;
                    sr_d = sr_q >> 1;
                    bc_d = bc_q - LW'(1);
                    if (bc_q == LW'(1)) begin
                        state_d = StDone;
                    end
                end else begin
                    tc_d = tc_q + TW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        w_d       = (state_d == StShift) ? sr_d[0] : IDLE_LVL;
        bit_vld_d = (state_d == StShift) && (tc_d == '0);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            bc_q      <= '0;
            tc_q      <= '0;
            w_q       <= IDLE_LVL;
            bit_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bc_q      <= bc_d;
            tc_q      <= tc_d;
            w_q       <= w_d;
            bit_vld_q <= bit_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign w       = w_q;
    assign bit_vld = bit_vld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: per-cycle expected {w,bit_vld,busy,done,z}
// where z comes from a four-ones-in-a-row detector fed by the serial stream.
module tb_serial_pattern_tx;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned T       = 4;
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      len;
    logic               w, bit_vld, busy, done;

    int vectors = 0;
    int errors  = 0;

    logic [4:0] exp_q[$];

    serial_pattern_tx #(
        .MAX_LEN (MAX_LEN),
        .TICK_DIV(T),
        .IDLE_LVL(1'b0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .pattern(pattern),
        .len    (len),
        .w      (w),
        .bit_vld(bit_vld),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Detector consuming one bit per bit_vld strobe; z pulses after a fourth consecutive 1.
    int   run;
    logic z;
    always_ff @(posedge clk) begin
        if (reset || done) begin
            run <= 0;
            z   <= 1'b0;
        end else begin
            z <= bit_vld && w && (run >= 3);
            if (bit_vld) run <= w ? ((run >= 3) ? 3 : run + 1) : 0;
        end
    end

    function automatic logic [4:0] observed();
        return {w, bit_vld, busy, done, z};
    endfunction

    // Sends one frame; restart_at re-asserts start with a different pattern mid-frame,
    // abort_at asserts reset after that sample. Use -1 to disable either.
    task automatic run_frame(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] ln,
                             input int restart_at, input int abort_at, input string name);
        int         eff;
        int         last;
        int         n;
        int         r;
        logic [MAX_LEN-1:0] zb;
        logic [4:0] e, o;
        logic       ew, ebv, ez;
        eff  = (ln > MAX_LEN) ? MAX_LEN : int'(ln);
        last = 2 + eff * T;
        r    = 0;
        zb   = '0;
        for (int b = 0; b < eff; b++) begin
            zb[b] = pat[b] && (r >= 3);
            r     = pat[b] ? ((r >= 3) ? 3 : r + 1) : 0;
        end
        for (int k = 0; k <= last; k++) begin
            ew  = (k >= 1 && k <= eff * T) ? pat[(k - 1) / T] : 1'b0;
            ebv = (k >= 1 && k <= eff * T) && ((k - 1) % T == 0);
            ez  = (k >= 2) && ((k - 2) % T == 0) && ((k - 2) / T < eff) && zb[(k - 2) / T];
            exp_q.push_back({ew, ebv, (k <= last - 1), (k == last - 1), ez});
        end
        pattern = pat;
        len     = ln;
        start   = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (1) begin
            e = exp_q.pop_front();
            o = observed();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s n=%0d {w,vld,busy,done,z} got %b expected %b", name, n, o, e);
            end
            start = 1'b0;
            if (n == abort_at) begin
                reset = 1'b1;
                exp_q.delete();
                @(posedge clk); #1;
                for (int i = 0; i < 6; i++) begin
                    o = observed();
                    vectors++;
                    if (o !== 5'b0) begin
                        errors++;
                        $display("FAIL %s_abort i=%0d got %b expected 00000", name, i, o);
                    end
                    reset = 1'b0;
                    @(posedge clk); #1;
                end
                break;
            end
            if (exp_q.size() == 0) break;
            if (n == restart_at) begin
                start   = 1'b1;
                pattern = ~pat;
                len     = LW'(MAX_LEN);
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        logic [4:0] o;
        reset   = 1'b1;
        start   = 1'b1;
        pattern = 16'hFFFF;
        len     = LW'(8);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            o = observed();
            vectors++;
            if (o !== 5'b0) begin
                errors++;
                $display("FAIL reset i=%0d got %b expected 00000", i, o);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            o = observed();
            vectors++;
            if (o !== 5'b0) begin
                errors++;
                $display("FAIL reset_release i=%0d got %b expected 00000", i, o);
            end
        end
    endtask

    task automatic test_basic();
        run_frame(16'h000F, LW'(8), -1, -1, "basic");
    endtask

    task automatic test_empty();
        run_frame(16'hFFFF, LW'(0), -1, -1, "empty");
    endtask

    task automatic test_back_to_back();
        run_frame(16'h000F, LW'(8), 5, -1, "restart_ignored");
        run_frame(16'h7FF0, LW'(16), -1, -1, "back_to_back");
    endtask

    task automatic test_abort();
        run_frame(16'h000F, LW'(8), -1, 2 + 3 * T, "abort");
        run_frame(16'hF00F, LW'(12), -1, -1, "after_abort");
    endtask

    task automatic test_clamp();
        run_frame(16'hA5A5, LW'(20), -1, -1, "clamp");
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        test_reset();
        test_basic();
        test_empty();
        test_back_to_back();
        test_abort();
        test_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
